mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch side (I) and the data-access side (D) of the 5-stage pipeline.
- Runs one transaction at a time and generates the memory latency internally.
- Returns read data plus a one-cycle done pulse to the owning requester. The D-side done drives the pipeline's d_doneM stall release.
- Round-robin fairness with D priority on a fresh tie.

Parameters:
- WORD_SIZE, 16, data and address width.
- MEM_LATENCY, 4, memory access cycles per transaction; legal range 1..15.
- CNT_W, 4, latency counter width; must hold MEM_LATENCY-1.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset_N  in  1  synchronous, active-low reset.
- i_req  in  1  instruction read request; held until i_done.
- i_addr  in  WORD_SIZE  instruction address.
- i_rdata  out  WORD_SIZE  instruction read data; valid while i_done=1.
- i_done  out  1  one-cycle completion pulse for I.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1=write, 0=read.
- d_addr  in  WORD_SIZE  data address.
- d_wdata  in  WORD_SIZE  store data.
- d_rdata  out  WORD_SIZE  load data; valid while d_done=1.
- d_done  out  1  one-cycle completion pulse for D.
- m_read  out  1  memory read strobe.
- m_write  out  1  memory write strobe.
- m_addr  out  WORD_SIZE  memory address.
- m_wdata  out  WORD_SIZE  memory write data.
- m_rdata  in  WORD_SIZE  memory read data; valid in the last BUSY cycle.
- busy  out  1  high in BUSY and RESP.

Behaviour:
- States: IDLE, BUSY, RESP. All outputs are registered.
- Reset (Reset_N=0 at a posedge) gives:
  - state=IDLE, last_grant=I;
  - m_read=m_write=0, m_addr=m_wdata=0;
  - i_done=d_done=0, i_rdata=d_rdata=0;
  - cnt=0, busy=0.
- Reset during BUSY or RESP abandons the transaction. No done pulse is issued.
- IDLE with no request: stay in IDLE, all strobes 0.
- IDLE with a request: grant, latch the owner's addr/wdata/we into m_*, load cnt=MEM_LATENCY-1, go to BUSY.
  - I-side grants drive m_read=1.
  - D-side grants drive m_write=d_we and m_read=!d_we.
- Grant rule:
  - only one requester asserting: that requester wins;
  - both asserting: D wins if last_grant=I, I wins if last_grant=D.
  - last_grant updates on every grant. I can therefore never starve behind back-to-back loads, and vice versa.
- BUSY:
  - m_* held constant;
  - cnt decrements each cycle;
  - at cnt=0: capture m_rdata into the owner's rdata, drop m_read/m_write, assert the owner's done, go to RESP.
  - BUSY lasts exactly MEM_LATENCY cycles.
- RESP:
  - owner's done=1 for exactly this cycle; rdata is valid;
  - the non-owner's done stays 0;
  - next state is always IDLE.
- Timing: request seen in cycle 0, BUSY in cycles 1..MEM_LATENCY, done in cycle MEM_LATENCY+1, new grant no earlier than cycle MEM_LATENCY+2. This one-cycle turnaround is mandatory.
- Requester contract:
  - on the edge ending the done cycle, the requester drops req or presents a new request;
  - the arbiter samples req only in IDLE, so a request still high in IDLE counts as new;
  - req or address changing during BUSY is ignored because the latched values are used.
- Writes: d_rdata is not updated and keeps its previous value; d_done still pulses.
- rdata registers hold their value outside done cycles.
- MEM_LATENCY=1: BUSY lasts one cycle and done arrives in cycle 2.

Decomposition:
- Shared package or constants include: state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), owner encoding (OWN_I=1'b0, OWN_D=1'b1), and WORD_SIZE from the existing constants file.
- One sub-module: mem_latency_counter.
  - Inputs: load, load value.
  - Outputs: cnt, zero flag.
  - Synchronous, reset to 0.

Test Plan:
- Single I read, MEM_LATENCY=4: i_req=1, i_addr=16'h0010, m_rdata=16'hABCD during cycles 1-4 -> m_read=1 cycles 1-4, i_done=1 only in cycle 5 with i_rdata=16'hABCD, busy=0 in cycle 6.
- Single D write: d_req=1, d_we=1, d_addr=16'h0020, d_wdata=16'h1234 -> m_write=1, m_read=0 cycles 1-4, m_addr=16'h0020, m_wdata=16'h1234; d_done in cycle 5; d_rdata unchanged.
- Simultaneous requests held from reset: both req=1 from cycle 0 -> D granted first (d_done cycle 5), I granted in cycle 6 (i_done cycle 11); D re-requesting after d_done is still served after I.
- Back-to-back D loads with I waiting: d_req and i_req high continuously -> grant order D, I, D, I; no requester is granted twice in a row while the other waits.
- Reset mid-transaction: Reset_N=0 in cycle 3 of a D read -> cycle 4: state IDLE, m_read=0, no d_done ever for that request; after release with both requests high, D granted first.
- MEM_LATENCY=1: i_req pulse sequence -> m_read high one cycle (cycle 1), i_done in cycle 2, next grant in cycle 3.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the I/D unified-memory port arbiter: word size,
// FSM state encoding, owner encoding and the round-robin pick rule.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // D wins a tie only when I held the previous grant, so neither side starves.
  function automatic logic pick_owner(input logic i_req, input logic d_req,
                                      input logic last_grant);
    logic own_s;
    if (d_req && (!i_req || (last_grant == OWN_I))) begin
      own_s = OWN_D;
    end else begin
      own_s = OWN_I;
    end
    return own_s;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_latency_counter.sv
// Down-counter that paces the fixed memory latency: loaded on a grant,
// then counts down to zero and parks there.
module mem_latency_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset_N,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Load on grant, otherwise decrement until zero.
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      cnt <= CNT_W'(0);
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != CNT_W'(0)) begin
      cnt <= cnt - CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign zero = (cnt == CNT_W'(0));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between instruction fetch (I)
// and data access (D): one transaction at a time, round-robin, registered outputs.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE   = WORD_SIZE_DEF,
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 m_read,
  output logic                 m_write,
  output logic [WORD_SIZE-1:0] m_addr,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  output logic                 busy
);

  localparam logic [CNT_W-1:0]     LOAD_VAL = CNT_W'(MEM_LATENCY - 1);
  localparam logic [WORD_SIZE-1:0] ZERO_W   = {WORD_SIZE{1'b0}};

  logic [1:0]       state_r;
  logic             owner_r;
  logic             last_grant_r;
  logic             grant_owner_s;
  logic             load_s;
  logic             cnt_zero_s;
  logic [CNT_W-1:0] cnt_unused_s;

  // Winner of a fresh grant; the counter loads on the same edge as the grant.
  always_comb begin
    grant_owner_s = pick_owner(i_req, d_req, last_grant_r);
    if ((state_r == ST_IDLE) && (i_req || d_req)) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  mem_latency_counter #(
    .CNT_W(CNT_W)
  ) u_latency_counter (
    .Clk      (Clk),
    .Reset_N  (Reset_N),
    .load     (load_s),
    .load_val (LOAD_VAL),
    .cnt      (cnt_unused_s),
    .zero     (cnt_zero_s)
  );

  // Transaction FSM; the m_* fields stay latched for the whole BUSY phase.
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWN_I;
      last_grant_r <= OWN_I;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_addr       <= ZERO_W;
      m_wdata      <= ZERO_W;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      i_rdata      <= ZERO_W;
      d_rdata      <= ZERO_W;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load_s) begin
            owner_r      <= grant_owner_s;
            last_grant_r <= grant_owner_s;
            busy         <= 1'b1;
            state_r      <= ST_BUSY;
            if (grant_owner_s == OWN_D) begin
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_write <= d_we;
              m_read  <= ~d_we;
            end else begin
              m_addr  <= i_addr;
              m_write <= 1'b0;
              m_read  <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // m_rdata is only valid in the final BUSY cycle.
          if (cnt_zero_s) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
            state_r <= ST_RESP;
            if (owner_r == OWN_D) begin
              d_done <= 1'b1;
              if (!m_write) begin
                d_rdata <= m_rdata;
              end else begin
                d_rdata <= d_rdata;
              end
            end else begin
              i_done  <= 1'b1;
              i_rdata <= m_rdata;
            end
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_RESP: begin
          i_done  <= 1'b0;
          d_done  <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          m_read  <= 1'b0;
          m_write <= 1'b0;
          i_done  <= 1'b0;
          d_done  <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run checked against a cycle-arithmetic transaction model with a memory array.
module tb_mem_port_arbiter;

  localparam int L = 4;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [15:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_done, d_done, m_read, m_write, busy;
  logic [15:0] i_rdata1, d_rdata1, m_addr1, m_wdata1;
  logic        i_done1, d_done1, m_read1, m_write1, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(L), .CNT_W(4)) u_dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(1), .CNT_W(4)) u_dut1 (
    .Clk(Clk), .Reset_N(Reset_N),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata1), .i_done(i_done1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata1), .d_done(d_done1),
    .m_read(m_read1), .m_write(m_write1), .m_addr(m_addr1), .m_wdata(m_wdata1),
    .m_rdata(m_rdata), .busy(busy1)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000; m_rdata = 16'h0000;
  endtask

  // Leaves the bench in "cycle 0": DUTs in reset state, Reset_N released.
  task automatic do_reset();
    Reset_N = 1'b0;
    tick();
    tick();
    Reset_N = 1'b1;
  endtask

  task automatic test_reset();
    logic [68:0] obs;
    idle_inputs();
    i_req = 1'b1; d_req = 1'b1;
    do_reset();
    idle_inputs();
    obs = {busy, m_read, m_write, i_done, d_done, m_addr, m_wdata, i_rdata, d_rdata};
    n_checks++;
    if (obs !== 69'd0) begin
      n_fail++; $display("FAIL reset_state: got %h expected 0", obs);
    end
    obs = {busy1, m_read1, m_write1, i_done1, d_done1, m_addr1, m_wdata1, i_rdata1, d_rdata1};
    n_checks++;
    if (obs !== 69'd0) begin
      n_fail++; $display("FAIL reset_state_lat1: got %h expected 0", obs);
    end
    tick();
    n_checks++;
    if ({busy, m_read, m_write, i_done, d_done} !== 5'b00000) begin
      n_fail++; $display("FAIL idle_no_req: got %b expected 00000", {busy, m_read, m_write, i_done, d_done});
    end
  endtask

  task automatic test_i_read();
    logic [4:0] exp;
    idle_inputs();
    do_reset();
    i_req = 1'b1; i_addr = 16'h0010; m_rdata = 16'hABCD;
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp = {(c <= 5), (c <= 4), 1'b0, (c == 5), 1'b0};
      n_checks++;
      if ({busy, m_read, m_write, i_done, d_done} !== exp) begin
        n_fail++; $display("FAIL i_read_c%0d: got %b expected %b", c, {busy, m_read, m_write, i_done, d_done}, exp);
      end
      if (c == 2) begin
        n_checks++;
        if (m_addr !== 16'h0010) begin
          n_fail++; $display("FAIL i_read_addr: got %h expected 0010", m_addr);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (i_rdata !== 16'hABCD) begin
          n_fail++; $display("FAIL i_read_data: got %h expected abcd", i_rdata);
        end
        i_req = 1'b0;
      end
    end
  endtask

  // A D read first so the following write can show d_rdata is left alone.
  task automatic test_d_write();
    logic [4:0] exp;
    idle_inputs();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      d_req = 1'b1; d_we = (k == 1);
      d_addr  = (k == 1) ? 16'h0020 : 16'h0030;
      d_wdata = (k == 1) ? 16'h1234 : 16'h0000;
      m_rdata = (k == 1) ? 16'hFFFF : 16'h5A5A;
      for (int c = 1; c <= 6; c++) begin
        tick();
        exp = {(c <= 5), (c <= 4) && (k == 0), (c <= 4) && (k == 1), 1'b0, (c == 5)};
        n_checks++;
        if ({busy, m_read, m_write, i_done, d_done} !== exp) begin
          n_fail++; $display("FAIL d_txn%0d_c%0d: got %b expected %b", k, c, {busy, m_read, m_write, i_done, d_done}, exp);
        end
        if (c == 3 && k == 1) begin
          n_checks++;
          if ({m_addr, m_wdata} !== {16'h0020, 16'h1234}) begin
            n_fail++; $display("FAIL d_write_fields: got %h expected 00201234", {m_addr, m_wdata});
          end
        end
        if (c == 5) begin
          n_checks++;
          if (d_rdata !== 16'h5A5A) begin
            n_fail++; $display("FAIL d_rdata_txn%0d: got %h expected 5a5a", k, d_rdata);
          end
          d_req = 1'b0;
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp;
    logic [15:0] ea;
    idle_inputs();
    i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0100; d_addr = 16'h0200; m_rdata = 16'h7777;
    do_reset();
    for (int c = 1; c <= 18; c++) begin
      tick();
      exp = {(c == 11), (c == 5) || (c == 17)};
      n_checks++;
      if ({i_done, d_done} !== exp) begin
        n_fail++; $display("FAIL simul_done_c%0d: got %b expected %b", c, {i_done, d_done}, exp);
      end
      if (c % 6 == 2) begin
        ea = (c == 8) ? 16'h0100 : 16'h0200;
        n_checks++;
        if (m_addr !== ea) begin
          n_fail++; $display("FAIL simul_owner_c%0d: got %h expected %h", c, m_addr, ea);
        end
      end
      if (c == 11) i_req = 1'b0;
      if (c == 17) d_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    logic d_turn;
    idle_inputs();
    i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0A0A; d_addr = 16'h0D0D; m_rdata = 16'h2222;
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      tick();
      d_turn = ((c / 6) % 2) == 0;
      exp = {(c % 6 == 5) && !d_turn, (c % 6 == 5) && d_turn};
      n_checks++;
      if ({i_done, d_done} !== exp) begin
        n_fail++; $display("FAIL b2b_done_c%0d: got %b expected %b", c, {i_done, d_done}, exp);
      end
      if (c % 6 == 3) begin
        n_checks++;
        if ({m_read, m_addr} !== {1'b1, d_turn ? 16'h0D0D : 16'h0A0A}) begin
          n_fail++; $display("FAIL b2b_grant_c%0d: got %b/%h expected d_turn=%b", c, m_read, m_addr, d_turn);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp;
    idle_inputs();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300; i_addr = 16'h0400; m_rdata = 16'h1111;
    do_reset();
    tick(); tick(); tick();
    n_checks++;
    if ({busy, m_read} !== 2'b11) begin
      n_fail++; $display("FAIL rmid_busy_c3: got %b expected 11", {busy, m_read});
    end
    Reset_N = 1'b0; i_req = 1'b1;
    tick();
    Reset_N = 1'b1;
    n_checks++;
    if ({busy, m_read, m_write, i_done, d_done} !== 5'b00000) begin
      n_fail++; $display("FAIL rmid_abandon: got %b expected 00000", {busy, m_read, m_write, i_done, d_done});
    end
    for (int c = 5; c <= 10; c++) begin
      tick();
      exp = {1'b0, (c == 9)};
      n_checks++;
      if ({i_done, d_done} !== exp) begin
        n_fail++; $display("FAIL rmid_done_c%0d: got %b expected %b", c, {i_done, d_done}, exp);
      end
      if (c == 5) begin
        n_checks++;
        if (m_addr !== 16'h0300) begin
          n_fail++; $display("FAIL rmid_d_first: got %h expected 0300", m_addr);
        end
      end
      if (c == 9) d_req = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_latency1();
    logic [2:0] exp;
    logic [15:0] ed;
    idle_inputs();
    i_req = 1'b1; i_addr = 16'h0040; m_rdata = 16'h4321;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp = {(c == 1) || (c == 2) || (c == 4) || (c == 5), (c == 1) || (c == 4), (c == 2) || (c == 5)};
      n_checks++;
      if ({busy1, m_read1, i_done1} !== exp) begin
        n_fail++; $display("FAIL lat1_c%0d: got %b expected %b", c, {busy1, m_read1, i_done1}, exp);
      end
      if (c == 2 || c == 5) begin
        ed = (c == 2) ? 16'h4321 : 16'h8765;
        n_checks++;
        if (i_rdata1 !== ed) begin
          n_fail++; $display("FAIL lat1_data_c%0d: got %h expected %h", c, i_rdata1, ed);
        end
      end
      if (c == 3) m_rdata = 16'h8765;
      if (c == 5) i_req = 1'b0;
    end
  endtask

  // Random requesters obeying the hold-until-done contract; the model predicts
  // each grant from the cycle arithmetic grant+L+2 and the round-robin rule.
  task automatic test_random();
    logic [15:0] mem [64];
    int          g;
    logic        own_d, last_d, twe, e_in, e_resp;
    logic [15:0] ta, tw, exp_ir, exp_dr;
    logic [4:0]  exp;
    for (int k = 0; k < 64; k++) mem[k] = 16'($urandom);
    idle_inputs();
    do_reset();
    g = -100; own_d = 1'b0; last_d = 1'b0; twe = 1'b0;
    ta = 16'h0000; tw = 16'h0000; exp_ir = 16'h0000; exp_dr = 16'h0000;
    for (int c = 0; c < 600; c++) begin
      e_in   = (c > g) && (c <= g + L);
      e_resp = (c == g + L + 1);
      exp = {e_in || e_resp, e_in && !twe, e_in && twe, e_resp && !own_d, e_resp && own_d};
      n_checks++;
      if ({busy, m_read, m_write, i_done, d_done} !== exp) begin
        n_fail++; $display("FAIL rand_ctrl_c%0d: got %b expected %b", c, {busy, m_read, m_write, i_done, d_done}, exp);
      end
      if (e_in) begin
        n_checks++;
        if (m_addr !== ta || (twe && m_wdata !== tw)) begin
          n_fail++; $display("FAIL rand_fields_c%0d: got %h/%h expected %h/%h", c, m_addr, m_wdata, ta, tw);
        end
      end
      if (e_resp) begin
        if (!own_d) exp_ir = mem[ta[5:0]];
        else if (!twe) exp_dr = mem[ta[5:0]];
        else mem[ta[5:0]] = tw;
      end
      n_checks++;
      if ({i_rdata, d_rdata} !== {exp_ir, exp_dr}) begin
        n_fail++; $display("FAIL rand_rdata_c%0d: got %h/%h expected %h/%h", c, i_rdata, d_rdata, exp_ir, exp_dr);
      end
      if (i_req) begin
        if (!own_d && c == g + L + 2) begin
          if ($urandom_range(1) == 1) i_addr = 16'($urandom);
          else i_req = 1'b0;
        end else if (!own_d && e_in) begin
          i_addr = 16'($urandom);
        end
      end else if ($urandom_range(2) == 0) begin
        i_req = 1'b1; i_addr = 16'($urandom);
      end
      if (d_req) begin
        if (own_d && c == g + L + 2) begin
          if ($urandom_range(1) == 1) begin
            d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
          end else begin
            d_req = 1'b0;
          end
        end else if (own_d && e_in) begin
          d_addr = 16'($urandom); d_wdata = 16'($urandom);
        end
      end else if ($urandom_range(2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      if (c >= g + L + 2 && (i_req || d_req)) begin
        own_d  = d_req && (!i_req || !last_d);
        last_d = own_d;
        g      = c;
        ta     = own_d ? d_addr : i_addr;
        tw     = d_wdata;
        twe    = own_d && d_we;
      end
      if (c == g + L) m_rdata = mem[m_addr[5:0]];
      else m_rdata = 16'($urandom);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    Reset_N = 1'b0;
    test_reset();
    test_i_read();
    test_d_write();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
